// File: rtl/dp_align.sv
// dp_align: aligns four signed mantissa products to their common (maximum) exponent.
// Latency: 2 cycles, S1 (max exponent and per-lane shift distance) then S2 (shift, negate, sticky).
// Backpressure: in_ready = ~out_valid | out_ready; when it is low, both stages hold, valids included.
// Option: define DP_ALIGN_STICKY_EN to build the per-lane shifted-out (sticky) flags; otherwise sticky_o is tied to 0.
module dp_align (
    input  logic        clk,
    input  logic        rst,
    input  logic [51:0] mul_1_comb,
    input  logic [51:0] mul_2_comb,
    input  logic [51:0] mul_3_comb,
    input  logic [51:0] mul_4_comb,
    input  logic        sign_1,
    input  logic        sign_2,
    input  logic        sign_3,
    input  logic        sign_4,
    input  logic [7:0]  exp_1,
    input  logic [7:0]  exp_2,
    input  logic [7:0]  exp_3,
    input  logic [7:0]  exp_4,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [53:0] aligned_1_o,
    output logic [53:0] aligned_2_o,
    output logic [53:0] aligned_3_o,
    output logic [53:0] aligned_4_o,
    output logic [7:0]  max_exp_o,
    output logic [3:0]  sticky_o,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int          LANES       = 4;
    // A shift of 53 or more clears the whole 53-bit magnitude.
    localparam logic [7:0]  SHIFT_LIMIT = 8'd53;

    // Lane views of the flat input ports
    logic [51:0] mul_in  [LANES];
    logic        sign_in [LANES];
    logic [7:0]  exp_in  [LANES];

    assign mul_in[0]  = mul_1_comb;
    assign mul_in[1]  = mul_2_comb;
    assign mul_in[2]  = mul_3_comb;
    assign mul_in[3]  = mul_4_comb;
    assign sign_in[0] = sign_1;
    assign sign_in[1] = sign_2;
    assign sign_in[2] = sign_3;
    assign sign_in[3] = sign_4;
    assign exp_in[0]  = exp_1;
    assign exp_in[1]  = exp_2;
    assign exp_in[2]  = exp_3;
    assign exp_in[3]  = exp_4;

    // S1 state
    logic        s1_vld_d,     s1_vld_q;
    logic [7:0]  s1_max_exp_d, s1_max_exp_q;
    logic [7:0]  s1_diff_d     [LANES];
    logic [7:0]  s1_diff_q     [LANES];
    logic [51:0] s1_mul_d      [LANES];
    logic [51:0] s1_mul_q      [LANES];
    logic        s1_sign_d     [LANES];
    logic        s1_sign_q     [LANES];

    // S2 state (the outputs)
    logic        out_vld_d,    out_vld_q;
    logic [7:0]  max_exp_d,    max_exp_q;
    logic [53:0] aligned_d     [LANES];
    logic [53:0] aligned_q     [LANES];

    logic        advance;
    logic [7:0]  exp_max;
    logic [52:0] mag           [LANES];
    logic [53:0] signed_mag    [LANES];

    // One advance signal for the whole pipe: move whenever the output slot is free or draining.
    assign advance  = ~out_vld_q | out_ready;
    assign in_ready = advance;

    // S1: find the common exponent and each lane's right-shift distance; hold while stalled.
    always_comb begin
        exp_max = exp_in[0];
        for (int k = 1; k < LANES; k++) begin
            if (exp_in[k] > exp_max) begin
                exp_max = exp_in[k];
            end
        end
        s1_vld_d     = s1_vld_q;
        s1_max_exp_d = s1_max_exp_q;
        for (int k = 0; k < LANES; k++) begin
            s1_diff_d[k] = s1_diff_q[k];
            s1_mul_d[k]  = s1_mul_q[k];
            s1_sign_d[k] = s1_sign_q[k];
        end
        if (advance) begin
            s1_vld_d     = in_valid;
            s1_max_exp_d = exp_max;
            for (int k = 0; k < LANES; k++) begin
                s1_diff_d[k] = exp_max - exp_in[k];
                s1_mul_d[k]  = mul_in[k];
                s1_sign_d[k] = sign_in[k];
            end
        end
    end

    // S2: shift each magnitude right (saturating to zero on large shifts), then apply the sign.
    always_comb begin
        out_vld_d = out_vld_q;
        max_exp_d = max_exp_q;
        for (int k = 0; k < LANES; k++) begin
            mag[k]        = (s1_diff_q[k] >= SHIFT_LIMIT) ? 53'd0
                                                          : ({1'b0, s1_mul_q[k]} >> s1_diff_q[k]);
            // Negating a zero magnitude yields zero, so a negative zero never appears.
            signed_mag[k] = s1_sign_q[k] ? (54'd0 - {1'b0, mag[k]}) : {1'b0, mag[k]};
            aligned_d[k]  = aligned_q[k];
        end
        if (advance) begin
            out_vld_d = s1_vld_q;
            max_exp_d = s1_max_exp_q;
            for (int k = 0; k < LANES; k++) begin
                aligned_d[k] = signed_mag[k];
            end
        end
    end

    // Pipeline registers, cleared asynchronously so in-flight data is discarded on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q     <= 1'b0;
            s1_max_exp_q <= 8'd0;
            out_vld_q    <= 1'b0;
            max_exp_q    <= 8'd0;
            for (int k = 0; k < LANES; k++) begin
                s1_diff_q[k] <= 8'd0;
                s1_mul_q[k]  <= 52'd0;
                s1_sign_q[k] <= 1'b0;
                aligned_q[k] <= 54'd0;
            end
        end else begin
            s1_vld_q     <= s1_vld_d;
            s1_max_exp_q <= s1_max_exp_d;
            out_vld_q    <= out_vld_d;
            max_exp_q    <= max_exp_d;
            for (int k = 0; k < LANES; k++) begin
                s1_diff_q[k] <= s1_diff_d[k];
                s1_mul_q[k]  <= s1_mul_d[k];
                s1_sign_q[k] <= s1_sign_d[k];
                aligned_q[k] <= aligned_d[k];
            end
        end
    end

`ifdef DP_ALIGN_STICKY_EN
    logic [3:0]  sticky_d, sticky_q;
    logic [52:0] lost_mask [LANES];

    // Sticky: flag any set product bit that falls off the right end of the shift.
    always_comb begin
        sticky_d = sticky_q;
        for (int k = 0; k < LANES; k++) begin
            // Low diff_k bits set; only meaningful below the saturation limit.
            lost_mask[k] = ~({53{1'b1}} << s1_diff_q[k]);
            if (advance) begin
                sticky_d[k] = (s1_diff_q[k] >= SHIFT_LIMIT) ? (|s1_mul_q[k])
                                                            : (|({1'b0, s1_mul_q[k]} & lost_mask[k]));
            end
        end
    end

    // Sticky register, aligned in time with the S2 outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 4'd0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_o = sticky_q;
`else
    assign sticky_o = 4'd0;
`endif

    assign aligned_1_o = aligned_q[0];
    assign aligned_2_o = aligned_q[1];
    assign aligned_3_o = aligned_q[2];
    assign aligned_4_o = aligned_q[3];
    assign max_exp_o   = max_exp_q;
    assign out_valid   = out_vld_q;

endmodule

// File: tb/tb_dp_align.sv
// tb_dp_align: directed-vector bench for dp_align with hand-computed expected values.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point or on the falling edge.
// Sticky expectations depend on DP_ALIGN_STICKY_EN, which is defined the same way for bench and design.
module tb_dp_align;

    logic        clk = 1'b0;
    logic        rst;
    logic [51:0] mul_1, mul_2, mul_3, mul_4;
    logic        sign_1, sign_2, sign_3, sign_4;
    logic [7:0]  exp_1, exp_2, exp_3, exp_4;
    logic        in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [53:0] aligned_1_o, aligned_2_o, aligned_3_o, aligned_4_o;
    logic [7:0]  max_exp_o;
    logic [3:0]  sticky_o;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef DP_ALIGN_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    localparam logic [51:0] ALL_F = 52'hF_FFFF_FFFF_FFFF;

    dp_align dut (
        .clk         (clk),
        .rst         (rst),
        .mul_1_comb  (mul_1),
        .mul_2_comb  (mul_2),
        .mul_3_comb  (mul_3),
        .mul_4_comb  (mul_4),
        .sign_1      (sign_1),
        .sign_2      (sign_2),
        .sign_3      (sign_3),
        .sign_4      (sign_4),
        .exp_1       (exp_1),
        .exp_2       (exp_2),
        .exp_3       (exp_3),
        .exp_4       (exp_4),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .aligned_1_o (aligned_1_o),
        .aligned_2_o (aligned_2_o),
        .aligned_3_o (aligned_3_o),
        .aligned_4_o (aligned_4_o),
        .max_exp_o   (max_exp_o),
        .sticky_o    (sticky_o),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    task automatic set_lane(input int k, input logic [51:0] m, input logic s, input logic [7:0] e);
        case (k)
            1: begin mul_1 = m; sign_1 = s; exp_1 = e; end
            2: begin mul_2 = m; sign_2 = s; exp_2 = e; end
            3: begin mul_3 = m; sign_3 = s; exp_3 = e; end
            default: begin mul_4 = m; sign_4 = s; exp_4 = e; end
        endcase
    endtask

    task automatic set_item(input int i);
        for (int k = 1; k <= 4; k++) begin
            set_lane(k, 52'd0, 1'b0, 8'(i));
        end
        mul_1 = 52'(i + 1);
    endtask

    // Present one vector for one cycle, then wait until its result is on the outputs.
    task automatic run_one();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        check_eq("one_lat1_vld", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check_eq("one_lat2_vld", 64'(out_valid), 64'd1);
    endtask

    task automatic check_bubble();
        @(posedge clk); #1;
        check_eq("bubble_vld", 64'(out_valid), 64'd0);
    endtask

    initial begin
        int sent;
        int rcv;
        logic exp_vld;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) set_lane(k, 52'd0, 1'b0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);
        check_eq("rst_aligned_1", 64'(aligned_1_o), 64'd0);
        check_eq("rst_max_exp",   64'(max_exp_o), 64'd0);
        check_eq("rst_sticky",    64'(sticky_o),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Equal exponents: no shift; negative and zero-magnitude lanes.
        set_lane(1, 52'h1,   1'b0, 8'd100);
        set_lane(2, 52'hABC, 1'b0, 8'd100);
        set_lane(3, 52'h0,   1'b1, 8'd100);
        set_lane(4, 52'h5,   1'b1, 8'd100);
        run_one();
        check_eq("eq_aligned_1", 64'(aligned_1_o), 64'h1);
        check_eq("eq_aligned_2", 64'(aligned_2_o), 64'hABC);
        check_eq("eq_aligned_3", 64'(aligned_3_o), 64'h0);
        check_eq("eq_aligned_4", 64'(aligned_4_o), 64'h3F_FFFF_FFFF_FFFB);
        check_eq("eq_max_exp",   64'(max_exp_o),   64'd100);
        check_eq("eq_sticky",    64'(sticky_o),    64'd0);
        check_bubble();

        // Shift with sign: lane 2 is 8>>2 negated; lane 3 loses a bit; lane 4 shifts out completely.
        set_lane(1, 52'h123,            1'b0, 8'd120);
        set_lane(2, 52'h8,              1'b1, 8'd118);
        set_lane(3, 52'h401,            1'b0, 8'd110);
        set_lane(4, 52'h8_0000_0000_0000, 1'b0, 8'd0);
        run_one();
        check_eq("sh_max_exp",   64'(max_exp_o),   64'd120);
        check_eq("sh_aligned_1", 64'(aligned_1_o), 64'h123);
        check_eq("sh_aligned_2", 64'(aligned_2_o), 64'h3F_FFFF_FFFF_FFFE);
        check_eq("sh_aligned_3", 64'(aligned_3_o), 64'h1);
        check_eq("sh_aligned_4", 64'(aligned_4_o), 64'h0);
        check_eq("sh_sticky",    64'(sticky_o),    STICKY_ON ? 64'hC : 64'h0);

        // Large differences: 51 (one bit survives), 190, and exactly 53.
        set_lane(1, 52'h0,  1'b1, 8'd200);
        set_lane(2, ALL_F,  1'b0, 8'd149);
        set_lane(3, ALL_F,  1'b0, 8'd10);
        set_lane(4, 52'h1,  1'b0, 8'd147);
        run_one();
        check_eq("big_max_exp",   64'(max_exp_o),   64'd200);
        check_eq("big_aligned_1", 64'(aligned_1_o), 64'h0);
        check_eq("big_aligned_2", 64'(aligned_2_o), 64'h1);
        check_eq("big_aligned_3", 64'(aligned_3_o), 64'h0);
        check_eq("big_aligned_4", 64'(aligned_4_o), 64'h0);
        check_eq("big_sticky",    64'(sticky_o),    STICKY_ON ? 64'hE : 64'h0);

        // Shift of 69 must not wrap to a small shift.
        set_lane(1, 52'h0, 1'b0, 8'd200);
        set_lane(2, 52'h0, 1'b0, 8'd200);
        set_lane(3, 52'h0, 1'b0, 8'd200);
        set_lane(4, ALL_F, 1'b1, 8'd131);
        run_one();
        check_eq("wrap_aligned_4", 64'(aligned_4_o), 64'h0);
        check_eq("wrap_sticky",    64'(sticky_o),    STICKY_ON ? 64'h8 : 64'h0);
        check_bubble();

        // Backpressure: four items, consumer stalls for cycles 2..4.
        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_valid  = (sent < 4);
            set_item(10 + sent);
            out_ready = !(cyc >= 2 && cyc <= 4);
            @(negedge clk);
            if (out_valid) begin
                check_eq("bp_head_data", 64'(aligned_1_o), 64'(11 + rcv));
                check_eq("bp_head_exp",  64'(max_exp_o),   64'(10 + rcv));
            end
            if (out_valid && !out_ready) check_eq("bp_in_ready", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) rcv++;
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_eq("bp_sent",     64'(sent), 64'd4);
        check_eq("bp_received", 64'(rcv),  64'd4);
        check_eq("bp_idle_vld", 64'(out_valid), 64'd0);

        // Full throughput: ten back-to-back items, results from cycle 2 on.
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 13; cyc++) begin
            in_valid = (cyc < 10);
            set_item(50 + cyc);
            @(negedge clk);
            exp_vld = (cyc >= 2 && cyc <= 11);
            check_eq("tp_valid", 64'(out_valid), 64'(exp_vld));
            if (exp_vld) begin
                check_eq("tp_data", 64'(aligned_1_o), 64'(51 + cyc - 2));
                check_eq("tp_exp",  64'(max_exp_o),   64'(50 + cyc - 2));
            end
            @(posedge clk); #1;
        end

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_item(30 + i);
            @(posedge clk); #1;
        end
        check_eq("mid_full_vld", 64'(out_valid), 64'd1);
        check_eq("mid_full_rdy", 64'(in_ready),  64'd0);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_vld",     64'(out_valid),   64'd0);
        check_eq("mid_rst_rdy",     64'(in_ready),    64'd1);
        check_eq("mid_rst_aligned", 64'(aligned_1_o), 64'd0);
        check_eq("mid_rst_exp",     64'(max_exp_o),   64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("mid_no_stale", 64'(out_valid), 64'd0);
        end
        set_item(5);
        mul_1 = 52'h77;
        run_one();
        check_eq("mid_after_data", 64'(aligned_1_o), 64'h77);
        check_eq("mid_after_exp",  64'(max_exp_o),   64'd5);
        check_bubble();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dp_align.md
DP_ALIGN -- requirements
Module: dp_align

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: mul_1_comb..mul_4_comb  input  52 each  unsigned mantissa products from the pipeline register upstream.
REQ-004 SHALL have ports: sign_1..sign_4  input  1 each  product signs (1 = negative).
REQ-005 SHALL have ports: exp_1..exp_4  input  8 each  unsigned product exponents.
REQ-006 SHALL have ports: in_valid  input  1  lane data valid; in_ready  output  1  stage accepts data.
REQ-007 SHALL have ports: aligned_1_o..aligned_4_o  output  54 each  two's-complement aligned products.
REQ-008 SHALL have ports: max_exp_o  output  8  common exponent; sticky_o  output  4  per-lane shifted-out flag.
REQ-009 SHALL have ports: out_valid  output  1  result valid; out_ready  input  1  consumer accepts.

Function
REQ-010 SHALL be a 2-stage pipeline, S1 then S2; latency is 2 cycles from accepted input to out_valid with no stall.
REQ-011 SHALL accept input on a cycle when in_valid and in_ready are both 1.
REQ-012 SHALL drive in_ready = ~out_valid | out_ready (global advance), combinationally.
REQ-013 SHALL hold all S1 and S2 registers, including valids, when advance is 0.
REQ-014 S1 SHALL register max_exp = max(exp_1..exp_4), diff_k = max_exp - exp_k (8-bit, never negative), mul_k and sign_k.
REQ-015 S1 valid SHALL load in_valid on advance, so a bubble enters when in_valid is 0.
REQ-016 S2 SHALL compute mag_k = {1'b0, mul_k} >> diff_k, giving 53 bits.
REQ-017 S2 SHALL force mag_k to 0 when diff_k >= 53, and SHALL NOT wrap the shift amount.
REQ-018 S2 SHALL register aligned_k_o = sign_k ? -mag_k : mag_k, sign-extended to 54 bits.
REQ-019 S2 SHALL produce aligned_k_o = 0 for a zero magnitude regardless of sign.
REQ-020 S2 SHALL register max_exp_o from S1; out_valid SHALL load S1 valid on advance.
REQ-021 Outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 When all exponents are equal, all diff_k SHALL be 0 and the products SHALL pass unshifted.
REQ-023 On the cycle out_valid=1, out_ready=1 and S1 valid=1, S2 SHALL load the new result with no bubble (full throughput).

Reset
REQ-024 rst=1 SHALL asynchronously clear all S1/S2 registers, aligned_k_o, max_exp_o, sticky_o and out_valid to 0.
REQ-025 After reset, in_ready SHALL read 1.
REQ-026 Reset asserted mid-operation SHALL discard in-flight data; no out_valid pulse occurs until 2 cycles after the next accepted input.

Configuration
REQ-027 With DP_ALIGN_STICKY_EN defined, S2 SHALL register sticky_o[k-1] = OR of the bits of mul_k shifted out, or |mul_k when diff_k >= 53.
REQ-028 Without DP_ALIGN_STICKY_EN, sticky_o SHALL be constant 0 and no sticky logic is synthesized; all other behaviour is identical.

Verification
REQ-029 Equal exponents: exp all 8'd100, mul_1=52'h1, signs 0 -> after 2 cycles aligned_1_o=54'h1, max_exp_o=100, out_valid=1.
REQ-030 Shift with sign: exp_1=120, exp_2=118, mul_2=52'h8, sign_2=1 -> max_exp_o=120, aligned_2_o = -2 (54'h3F_FFFF_FFFF_FFFE).
REQ-031 Large diff: exp_1=200, exp_3=10, mul_3=52'hF_FFFF_FFFF_FFFF -> aligned_3_o=0; sticky_o[2]=1 with DP_ALIGN_STICKY_EN, else 0.
REQ-032 Backpressure: stream 4 inputs, out_ready=0 for 3 cycles -> in_ready=0, outputs frozen, no result lost or duplicated after out_ready=1.
REQ-033 Full throughput: in_valid=1 and out_ready=1 for 10 cycles -> 10 consecutive out_valid beats starting at cycle 2, in order.
REQ-034 Reset mid-flight: assert rst with both stages valid -> out_valid=0 immediately, in_ready=1, no stale output after release.
